// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, imem fetch handshake and next-PC select; FETCH_PERF_EN adds retire/redirect counters.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count
`endif
);
  typedef enum logic [1:0] {RESET, REQ, WAIT, HOLD} state_t;
  state_t state, state_next;
  logic retire, redirect;
  logic [31:0] next_pc;
  assign pc_plus4 = pc + 32'd4;
  assign imem_req_addr = pc;
  assign opcode = instr[31:26];
  assign retire = state == HOLD && instr_ready;
  assign redirect = jump | (branch & zero);
  assign next_pc = jump ? {pc_plus4[31:28], instr[25:0], 2'b00}
                 : branch & zero ? pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}
                 : pc_plus4;
  always_comb begin
    state_next = state == RESET ? REQ
               : state == REQ ? (imem_req_ready ? WAIT : REQ)
               : state == WAIT ? (imem_resp_valid ? HOLD : WAIT)
               : (instr_ready ? REQ : HOLD);
    imem_req_valid = state == REQ;
    instr_valid = state == HOLD;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET;
      pc <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_next;
      if (state == WAIT && imem_resp_valid) instr <= imem_resp_data;
      if (retire) pc <= next_pc;
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      redirect_count <= '0;
    end else if (retire) begin
      fetch_count <= fetch_count + 32'd1;
      if (redirect) redirect_count <= redirect_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed plus random fetches against a next-PC reference model (FETCH_PERF_EN aware).
module tb_instruction_fetch_unit;
  logic clk = 0, reset = 1, imem_req_ready = 0, imem_resp_valid = 0, instr_ready = 0;
  logic branch = 0, zero = 0, jump = 0;
  logic [31:0] imem_resp_data = 0;
  logic imem_req_valid, instr_valid;
  logic [31:0] imem_req_addr, instr, pc, pc_plus4;
  logic [5:0] opcode;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, redirect_count;
`endif
  int passed = 0, failed = 0, cyc = 0;
  logic [31:0] exp_pc = 0, exp_fetch = 0, exp_redir = 0;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .pc(pc), .pc_plus4(pc_plus4),
    .instr_ready(instr_ready), .branch(branch), .zero(zero), .jump(jump)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .redirect_count(redirect_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic b, input logic z, input logic j);
    logic [31:0] seq;
    int off;
    seq = p + 32'd4;
    off = $signed(w[15:0]);
    if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (b && z) return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic check_perf();
`ifdef FETCH_PERF_EN
    check("fetch_count", fetch_count, exp_fetch);
    check("redirect_count", redirect_count, exp_redir);
`endif
  endtask

  task automatic fetch(input logic [31:0] w, input logic b, input logic z, input logic j,
                       input int rd, input int wd, input int hd);
    int start;
    start = cyc;
    check("req_valid", 32'(imem_req_valid), 32'd1);
    check("req_addr", imem_req_addr, exp_pc);
    repeat (rd) begin
      imem_resp_valid = 1'($urandom);
      tick();
      check("req_valid_held", 32'(imem_req_valid), 32'd1);
      check("req_addr_held", imem_req_addr, exp_pc);
    end
    imem_resp_valid = 0;
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    check("wait_req_valid", 32'(imem_req_valid), 32'd0);
    check("wait_instr_valid", 32'(instr_valid), 32'd0);
    repeat (wd) tick();
    imem_resp_valid = 1;
    imem_resp_data = w;
    tick();
    imem_resp_valid = 0;
    imem_resp_data = $urandom;
    check("instr_valid", 32'(instr_valid), 32'd1);
    check("instr", instr, w);
    check("opcode", 32'(opcode), 32'(w[31:26]));
    check("pc", pc, exp_pc);
    check("pc_plus4", pc_plus4, exp_pc + 32'd4);
    repeat (hd) begin
      branch = 1'($urandom);
      zero = 1'($urandom);
      jump = 1'($urandom);
      imem_resp_valid = 1;
      tick();
      check("hold_instr", instr, w);
      check("hold_pc", pc, exp_pc);
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_no_req", 32'(imem_req_valid), 32'd0);
    end
    imem_resp_valid = 0;
    branch = b;
    zero = z;
    jump = j;
    instr_ready = 1;
    tick();
    instr_ready = 0;
    branch = 0;
    zero = 0;
    jump = 0;
    exp_pc = model_next(exp_pc, w, b, z, j);
    exp_fetch++;
    if (j || (b && z)) exp_redir++;
    if (rd == 0 && wd == 0 && hd == 0) check("throughput", 32'(cyc - start), 32'd3);
    check_perf();
  endtask

  initial begin
    repeat (2) tick();
    check("rst_pc", pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    check("rst_addr", imem_req_addr, 32'h0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check_perf();
    reset = 0;
    check("first_cycle_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    fetch(32'h1000_FFFE, 1, 1, 0, 0, 0, 0);
    check("wrap_target", imem_req_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_0020, 0, 0, 0, 0, 0, 0);
    check("wrap_to_zero", imem_req_addr, 32'h0);
    for (int i = 0; i < 4; i++) fetch($urandom, 0, 0, 0, 0, 0, 0);
    check("seq_end", imem_req_addr, 32'h10);
    fetch(32'h0810_0000, 0, 0, 1, 0, 0, 0);
    check("jump_region", imem_req_addr, 32'h0040_0000);
    fetch(32'h0800_0010, 0, 0, 1, 0, 0, 0);
    check("jump_target", imem_req_addr, 32'h0000_0040);
    fetch(32'h0800_0040, 0, 0, 1, 0, 0, 0);
    fetch(32'h1000_FFFE, 1, 1, 0, 0, 0, 0);
    check("branch_taken", imem_req_addr, 32'h0FC);
    fetch(32'h0800_0040, 0, 0, 1, 0, 0, 0);
    fetch(32'h1000_FFFE, 1, 0, 0, 0, 0, 0);
    check("branch_not_taken", imem_req_addr, 32'h104);
    fetch(32'h0800_0040, 0, 0, 1, 0, 0, 0);
    fetch(32'h1000_FFFE, 1, 1, 1, 0, 0, 0);
    check("jump_over_branch", imem_req_addr, 32'h0003_FFF8);
    fetch($urandom, 0, 0, 0, 4, 2, 5);
    check("req_valid_pre_reset", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    reset = 1;
    tick();
    reset = 0;
    imem_resp_valid = 1;
    imem_resp_data = 32'hDEAD_BEEF;
    exp_pc = 0;
    exp_fetch = 0;
    exp_redir = 0;
    check("wrst_instr_valid", 32'(instr_valid), 32'd0);
    check("wrst_pc", pc, 32'h0);
    check("wrst_instr", instr, 32'h0);
    check("wrst_req_valid", 32'(imem_req_valid), 32'd0);
    check_perf();
    tick();
    imem_resp_valid = 0;
    check("wrst_restart_instr", instr, 32'h0);
    fetch(32'h0000_0001, 0, 0, 0, 0, 0, 0);
    fetch(32'h0000_0002, 0, 0, 0, 0, 1, 0);
    fetch(32'h0800_0040, 0, 0, 1, 0, 0, 0);
`ifdef FETCH_PERF_EN
    check("perf_fetch3", fetch_count, 32'd3);
    check("perf_redir1", redirect_count, 32'd1);
`endif
    for (int i = 0; i < 40; i++)
      fetch($urandom, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch front end for the single-cycle MIPS datapath. Holds the PC and fetches one 32-bit instruction word at a time from instruction memory over a valid/ready request channel plus a response channel. Presents the word and its opcode field to the control unit, then computes the next PC from the Branch/Jump decode and the ALU Zero flag. It is the producer side of the opcode that the control unit decodes, and the consumer of that unit's Branch and Jump outputs.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 00.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  byte address of the fetched word (= pc).
- imem_req_ready  in  1  memory accepts the request when high with imem_req_valid.
- imem_resp_valid  in  1  response word valid; one-cycle pulse.
- imem_resp_data  in  32  instruction word.
- instr_valid  out  1  instr/opcode/pc hold a fetched instruction.
- instr  out  32  fetched instruction word.
- opcode  out  6  instr[31:26], goes to the control unit.
- pc  out  32  address of instr.
- pc_plus4  out  32  pc + 4.
- instr_ready  in  1  datapath retires instr this cycle.
- branch  in  1  Branch from the control unit.
- zero  in  1  ALU Zero flag.
- jump  in  1  Jump from the control unit.

## Operation
- FSM states: RESET, REQ, WAIT, HOLD.
- RESET: entered on reset. Next cycle goes to REQ.
- REQ: imem_req_valid=1 and imem_req_addr=pc. On imem_req_ready goes to WAIT. The address is stable while waiting.
- WAIT: on imem_resp_valid, captures imem_resp_data into instr and goes to HOLD. imem_resp_valid is ignored in every other state.
- HOLD: instr_valid=1. On instr_ready the fetch unit updates the PC and goes to REQ.
- Next-PC is sampled in the HOLD cycle with instr_ready=1. Priority order:
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else branch & zero: pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}.
  - else pc_plus4.
- All adds are 32-bit modulo 2^32. pc+4 at 32'hFFFF_FFFC wraps to 0. Bits [1:0] of pc are always 00.
- branch, zero and jump are ignored outside HOLD, and ignored when instr_ready=0.
- Reset mid-operation:
  - Any outstanding request is abandoned and instr_valid drops in the next cycle.
  - Instruction memory shares reset and discards in-flight responses.
- Reset values: imem_req_valid=0, instr_valid=0, instr=0, opcode=0, pc=RESET_PC, pc_plus4=RESET_PC+4, imem_req_addr=RESET_PC.

## Timing
- imem_req_valid rises in the 2nd cycle after reset deasserts (RESET→REQ).
- REQ to WAIT takes 1 cycle when imem_req_ready is high in the same cycle as valid.
- instr/instr_valid are registered. They appear the cycle after imem_resp_valid.
- The new pc appears the cycle after the instr_ready handshake, together with imem_req_valid=1.
- Best-case throughput is 1 instruction per 3 cycles (REQ, WAIT, HOLD).
- instr, opcode and pc stay stable for the whole of HOLD, however long instr_ready stays low.

## Configuration
- FETCH_PERF_EN defined: adds two output ports.
  - fetch_count (32-bit): increments on each HOLD retire.
  - redirect_count (32-bit): increments when a retire selects the jump or taken-branch target.
  - Both reset to 0 and wrap modulo 2^32.
- FETCH_PERF_EN undefined: neither port nor its counter exists; all other behaviour is identical.

## Test plan
- Sequential fetch: reset with RESET_PC=0, memory with ready=1 and 1-cycle response, instr_ready=1, no branch/jump → request addresses 0, 4, 8, 12; one instr_valid every 3 cycles.
- Jump: instr=32'h0800_0010 at pc=0x0040_0000, jump=1 → next imem_req_addr=0x0000_0040.
- Branch: instr imm=16'hFFFE at pc=0x100.
  - branch=1, zero=1 → next pc=0x0FC.
  - branch=1, zero=0 → next pc=0x104.
  - jump=1 and branch=1 together → the jump target wins.
- Backpressure:
  - imem_req_ready low for 4 cycles → imem_req_valid and the address are held.
  - instr_ready low for 5 cycles in HOLD → instr/pc unchanged; no new request; a spurious imem_resp_valid is ignored.
- Reset in WAIT: assert reset for 1 cycle → instr_valid=0, pc=RESET_PC, fetch restarts at RESET_PC. With FETCH_PERF_EN, fetch_count=0 after 2 sequential and 1 jump retire gives fetch_count=3, redirect_count=1.
